serial_add_ctrl: RTL and testbench

- Sequencer that time-shares the team's one-bit full-adder cell across a WIDTH-bit addition, one bit per clock, LSB first.
- Owns operand shift registers, the carry flip-flop, the result register and a start/busy/done handshake.
- Sits between a requester, such as a test sequencer or microcontroller datapath, and a single instance of the full-adder cell (ports a, b, cin, sum, cout).

---
 rtl/serial_add_ctrl_if.sv | 22 ++
 rtl/serial_add_ctrl.sv | 109 ++++++++++
 tb/tb_serial_add_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - requester-side handshake and result bundle for serial_add_ctrl (optional ovf under SERIAL_ADD_OVF_EN)
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (output start, op_a, op_b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, op_a, op_b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, op_a, op_b, cin, input busy, done, sum, cout);
    modport slave  (input start, op_a, op_b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial WIDTH-bit adder sequencer around one full-adder cell; SERIAL_ADD_OVF_EN adds ovf
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             carry_q;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    full_adder_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Result bits enter from the MSB side so bit 0 lands at the LSB after WIDTH shifts.
    assign res_next = {fa_sum, res_sr};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            carry_q <= 1'b0;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sr    <= bus.op_a;
                        b_sr    <= bus.op_b;
                        carry_q <= bus.cin;
                        cnt     <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_sr  <= res_next[WIDTH-1:1];
                    carry_q <= fa_cout;
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    cnt     <= cnt + 1'b1;
                    // Published results change only here, so they are never partial.
                    if (last_bit) begin
                        sum_q  <= res_next;
                        cout_q <= fa_cout;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    // In the last RUN cycle carry_q is the carry into the MSB and fa_cout the carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == S_RUN && last_bit) begin
            ovf_q <= carry_q ^ fa_cout;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy = (state == S_RUN);
    assign bus.done = (state == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl (honours SERIAL_ADD_OVF_EN)
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raises start after an edge, drops it after the accepting edge, then waits for done.
    // lat counts edges from the one before start was raised up to the edge entering DONE.
    task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                           output int lat, output int busy_cnt, output logic ok);
        lat = 0; busy_cnt = 0; ok = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.cin = c;
        @(posedge clk);
        lat = 1;
        #1 bus.start = 1'b0; bus.op_a = 8'($urandom); bus.op_b = 8'($urandom); bus.cin = 1'($urandom);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) ok = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        chk("done_timeout", 32'(ok), 32'd1);
    endtask

    int   lat;
    int   bcnt;
    logic ok;
    int   dcnt;
    int   gap;
    logic [7:0] s_seen;

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add 0F + 01
        run_add(8'h0F, 8'h01, 1'b0, lat, bcnt, ok);
        chk("basic_latency", 32'(lat), 32'(WIDTH + 1));
        chk("basic_busy_cycles", 32'(bcnt), 32'(WIDTH));
        chk("basic_sum", 32'(bus.sum), 32'h10);
        chk("basic_cout", 32'(bus.cout), 32'd0);
        @(posedge clk);

        // Reset mid-RUN aborts; previous result 10 must clear
        @(posedge clk);
        #1 bus.start = 1'b1; bus.op_a = 8'h5A; bus.op_b = 8'h33; bus.cin = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_sum", 32'(bus.sum), 32'd0);
        chk("midrst_cout", 32'(bus.cout), 32'd0);
        #2 rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        chk("midrst_no_done", 32'(dcnt), 32'd0);
        chk("midrst_idle", 32'(bus.busy), 32'd0);

        // Carry chain wrap FF + 00 + 1
        run_add(8'hFF, 8'h00, 1'b1, lat, bcnt, ok);
        chk("wrap_sum", 32'(bus.sum), 32'h00);
        chk("wrap_cout", 32'(bus.cout), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
        chk("wrap_ovf", 32'(bus.ovf), 32'd0);
`endif
        @(posedge clk);

        // Signed overflow 7F + 01
        run_add(8'h7F, 8'h01, 1'b0, lat, bcnt, ok);
        chk("sovf_sum", 32'(bus.sum), 32'h80);
        chk("sovf_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("sovf_ovf", 32'(bus.ovf), 32'd1);
`endif
        @(posedge clk);

        // Start while busy is ignored; previous sum 80 holds during RUN
        @(posedge clk);
        #1 bus.start = 1'b1; bus.op_a = 8'h03; bus.op_b = 8'h04; bus.cin = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.start = 1'b1; bus.op_a = 8'hAA;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("ign_busy", 32'(bus.busy), 32'd1);
        chk("ign_sum_hold", 32'(bus.sum), 32'h80);
        dcnt = 0; s_seen = 8'hxx;
        for (int i = 0; i < 30; i++) begin
            if (bus.done) begin
                dcnt++;
                s_seen = bus.sum;
            end
            @(negedge clk);
        end
        chk("ign_done_count", 32'(dcnt), 32'd1);
        chk("ign_sum", 32'(s_seen), 32'h07);

        // Back-to-back with start held high
        @(posedge clk);
        #1 bus.start = 1'b1; bus.op_a = 8'h80; bus.op_b = 8'h80; bus.cin = 1'b0;
        @(posedge clk);
        #1 bus.op_a = 8'h12; bus.op_b = 8'h34;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = bus.done;
        end
        chk("b2b_first_seen", 32'(ok), 32'd1);
        chk("b2b_sum1", 32'(bus.sum), 32'h00);
        chk("b2b_cout1", 32'(bus.cout), 32'd1);
        gap = 0; ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            gap++;
            ok = bus.done;
        end
        bus.start = 1'b0;
        chk("b2b_second_seen", 32'(ok), 32'd1);
        chk("b2b_gap", 32'(gap), 32'(WIDTH + 2));
        chk("b2b_sum2", 32'(bus.sum), 32'h46);
        chk("b2b_cout2", 32'(bus.cout), 32'd0);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
